pio_pwm_leds: RTL and testbench

- Parametrised successor to the plain 10-bit LED output PIO on the Avalon-MM light bus.
- NUM_CH output channels; each channel independently selectable as direct, PWM-dimmed, or blinking.
- Shared prescaler, PWM counter and blink counter.
- Memory-mapped from the HPS lightweight bridge; drives the LED conduit exported at the soc_system top.

---
 rtl/pio_pwm_pkg.sv | 33 +++
 rtl/pio_pwm_leds_if.sv | 20 ++
 rtl/pio_pwm_timebase.sv | 42 ++++
 rtl/pio_pwm_leds.sv | 110 +++++++++++
 tb/tb_pio_pwm_leds.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pio_pwm_pkg.sv
// Shared register offsets, channel-mode encoding and CHCFG field layout
// for the PWM/blink LED PIO.
package pio_pwm_pkg;

   localparam int unsigned ADDR_DATA  = 0;
   localparam int unsigned ADDR_SET   = 1;
   localparam int unsigned ADDR_CLR   = 2;
   localparam int unsigned ADDR_PRESC = 3;
   localparam int unsigned ADDR_CH0   = 4;

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_PWM    = 2'd1,
      MODE_BLINK  = 2'd2
   } mode_e;

   localparam int unsigned MODE_LSB = 0;
   localparam int unsigned MODE_W   = 2;
   localparam int unsigned DUTY_LSB = 2;

   // Encoding 3 is reserved and behaves as direct.
   function automatic logic chan_next(input logic [MODE_W-1:0] mode,
                                      input logic data_bit,
                                      input logic pwm_on,
                                      input logic blink_on);
      case (mode)
         MODE_PWM:   chan_next = data_bit & pwm_on;
         MODE_BLINK: chan_next = data_bit & blink_on;
         default:    chan_next = data_bit;
      endcase
   endfunction

endpackage

// File: rtl/pio_pwm_leds_if.sv
// Avalon-MM slave bus bundle for the LED PIO (no waitrequest, read latency 1).
interface pio_pwm_leds_if #(
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata
   );
endinterface

// File: rtl/pio_pwm_timebase.sv
// Shared prescaler, PWM counter and blink counter driving all LED channels.
module pio_pwm_timebase #(
   parameter int unsigned PRESC_W = 16,
   parameter int unsigned DUTY_W  = 8,
   parameter int unsigned BLINK_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PRESC_W-1:0] presc,
   input  logic               presc_wr,
   output logic               tick,
   output logic [DUTY_W-1:0]  pwm_cnt,
   output logic               blink_msb
);

   logic [PRESC_W-1:0] presc_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic               wrap;

   // The tick in the cycle of a PRESCALE write still uses the old terminal count.
   assign tick      = (presc_cnt == presc);
   assign wrap      = tick && (pwm_cnt == '1);
   assign blink_msb = blink_cnt[BLINK_W-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_cnt <= '0;
         pwm_cnt   <= '0;
         blink_cnt <= '0;
      end else begin
         if (presc_wr || tick)
            presc_cnt <= '0;
         else
            presc_cnt <= presc_cnt + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 1'b1;
         if (wrap)
            blink_cnt <= blink_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pio_pwm_leds.sv
// LED output PIO with per-channel direct / PWM-dimmed / blink modes,
// Avalon-MM register file and registered LED conduit.
module pio_pwm_leds
   import pio_pwm_pkg::*;
#(
   parameter int unsigned NUM_CH  = 10,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned PRESC_W = 16,
   parameter int unsigned DUTY_W  = 8,
   parameter int unsigned BLINK_W = 8
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   pio_pwm_leds_if.slave       avs,
   output logic [NUM_CH-1:0]   leds_export
);

   localparam int unsigned CFG_W = DUTY_W + 2;

   localparam logic [ADDR_W-1:0] A_DATA  = ADDR_W'(ADDR_DATA);
   localparam logic [ADDR_W-1:0] A_SET   = ADDR_W'(ADDR_SET);
   localparam logic [ADDR_W-1:0] A_CLR   = ADDR_W'(ADDR_CLR);
   localparam logic [ADDR_W-1:0] A_PRESC = ADDR_W'(ADDR_PRESC);

   logic [NUM_CH-1:0]  data;
   logic [PRESC_W-1:0] presc;
   logic [CFG_W-1:0]   chcfg [NUM_CH];
   logic               wr_data, wr_set, wr_clr, wr_presc;
   logic [31:0]        rd_val;
   logic [NUM_CH-1:0]  led_next;
   logic [DUTY_W-1:0]  pwm_cnt;
   logic               blink_msb;
   logic               tick_unused;

   assign wr_data  = avs.avs_write && (avs.avs_address == A_DATA);
   assign wr_set   = avs.avs_write && (avs.avs_address == A_SET);
   assign wr_clr   = avs.avs_write && (avs.avs_address == A_CLR);
   assign wr_presc = avs.avs_write && (avs.avs_address == A_PRESC);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         data  <= '0;
         presc <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            chcfg[i] <= '0;
      end else begin
         if (wr_data)
            data <= avs.avs_writedata[NUM_CH-1:0];
         else if (wr_set)
            data <= data | avs.avs_writedata[NUM_CH-1:0];
         else if (wr_clr)
            data <= data & ~avs.avs_writedata[NUM_CH-1:0];
         if (wr_presc)
            presc <= avs.avs_writedata[PRESC_W-1:0];
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (avs.avs_write && (avs.avs_address == ADDR_W'(ADDR_CH0 + i)))
               chcfg[i] <= avs.avs_writedata[CFG_W-1:0];
      end
   end

   // CLR and anything past the last CHCFG fall through to zero.
   always_comb begin
      rd_val = '0;
      case (avs.avs_address)
         A_DATA:  rd_val = 32'(data);
         A_SET:   rd_val = 32'(leds_export);
         A_PRESC: rd_val = 32'(presc);
         default: begin
            for (int unsigned i = 0; i < NUM_CH; i++)
               if (avs.avs_address == ADDR_W'(ADDR_CH0 + i))
                  rd_val = 32'(chcfg[i]);
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n)
         avs.avs_readdata <= '0;
      else if (avs.avs_read)
         avs.avs_readdata <= rd_val;
   end

   pio_pwm_timebase #(
      .PRESC_W (PRESC_W),
      .DUTY_W  (DUTY_W),
      .BLINK_W (BLINK_W)
   ) u_timebase (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .presc     (presc),
      .presc_wr  (wr_presc),
      .tick      (tick_unused),
      .pwm_cnt   (pwm_cnt),
      .blink_msb (blink_msb)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign led_next[i] = chan_next(chcfg[i][MODE_LSB +: MODE_W], data[i],
                                     pwm_cnt < chcfg[i][DUTY_LSB +: DUTY_W],
                                     blink_msb);
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n)
         leds_export <= '0;
      else
         leds_export <= led_next;
   end

endmodule

// File: tb/tb_pio_pwm_leds.sv
// Directed self-checking bench for pio_pwm_leds: register map, latency,
// PWM duty, prescaler restart, reset behaviour and blink timing.
module tb_pio_pwm_leds;

   localparam int unsigned NUM_CH = 10;
   localparam int unsigned ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] leds;
   int unsigned       total = 0;
   int unsigned       bad = 0;

   pio_pwm_leds_if #(.ADDR_W(ADDR_W)) bus ();

   pio_pwm_leds #(
      .NUM_CH  (NUM_CH),
      .ADDR_W  (ADDR_W),
      .PRESC_W (16),
      .DUTY_W  (8),
      .BLINK_W (8)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .avs           (bus.slave),
      .leds_export   (leds)
   );

   always #5 clk = ~clk;

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every bus task starts at a falling edge and consumes exactly one rising edge.
   task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      @(negedge clk);
      bus.avs_read    = 1'b0;
      d = bus.avs_readdata;
   endtask

   task automatic rd_check(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      check(tag, v, exp);
   endtask

   // Reset held for three edges with a write strobe that must be ignored.
   task automatic do_reset();
      rst_n             = 1'b0;
      bus.avs_address   = '0;
      bus.avs_writedata = 32'hFFFF_FFFF;
      bus.avs_write     = 1'b1;
      repeat (3) @(negedge clk);
      bus.avs_write     = 1'b0;
      rst_n             = 1'b1;
   endtask

   task automatic count_high(input int unsigned ch, output int unsigned n);
      n = 0;
      repeat (256) begin
         @(negedge clk);
         if (leds[ch]) n++;
      end
   endtask

   initial begin
      int unsigned n;
      logic        found;

      rst_n             = 1'b0;
      bus.avs_address   = '0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      bus.avs_read      = 1'b0;
      @(negedge clk);

      // Reset state
      do_reset();
      check("rst_leds", 32'(leds), 32'h0);
      check("rst_rdata", bus.avs_readdata, 32'h0);
      rd_check("rst_data", 5'd0, 32'h0);
      rd_check("rst_presc", 5'd3, 32'h0);
      rd_check("rst_ch0", 5'd4, 32'h0);

      // Set / clear and output latency
      wr(5'd0, 32'h3FF);
      wr(5'd2, 32'h00F);
      wr(5'd1, 32'h001);
      check("set_lat0", 32'(leds), 32'h3F0);
      @(negedge clk);
      check("set_lat1", 32'(leds), 32'h3F1);
      rd_check("setclr_data", 5'd0, 32'h3F1);
      rd_check("set_rd_live", 5'd1, 32'h3F1);
      rd_check("clr_rd_zero", 5'd2, 32'h0);

      // Map edges
      rd_check("unmapped_rd", 5'(4 + NUM_CH), 32'h0);
      wr(5'd20, 32'hFFFF_FFFF);
      rd_check("unmapped_wr_presc", 5'd3, 32'h0);
      rd_check("unmapped_wr_ch0", 5'd4, 32'h0);
      rd_check("unmapped_wr_data", 5'd0, 32'h3F1);
      repeat (3) @(negedge clk);
      check("rd_hold", bus.avs_readdata, 32'h3F1);

      bus.avs_address   = 5'd0;
      bus.avs_writedata = 32'h055;
      bus.avs_write     = 1'b1;
      bus.avs_read      = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
      bus.avs_read      = 1'b0;
      check("rw_old", bus.avs_readdata, 32'h3F1);
      rd_check("rw_new", 5'd0, 32'h055);

      wr(5'd3, 32'hFFFF_FFFF);
      rd_check("presc_width", 5'd3, 32'h0000_FFFF);
      wr(5'd3, 32'h0);
      wr(5'd5, 32'hFFFF_FFFF);
      rd_check("chcfg_width", 5'd5, 32'h0000_03FF);
      wr(5'd0, 32'h002);
      @(negedge clk);
      check("mode3_direct", 32'(leds), 32'h002);

      // PWM duty at prescale 0
      do_reset();
      wr(5'd0, 32'h1);
      wr(5'd4, 32'h101);
      repeat (2) @(negedge clk);
      count_high(0, n);
      check("pwm_duty64", n, 32'd64);
      wr(5'd4, 32'h001);
      repeat (2) @(negedge clk);
      count_high(0, n);
      check("pwm_duty0", n, 32'd0);
      wr(5'd4, 32'h3FD);
      repeat (2) @(negedge clk);
      count_high(0, n);
      check("pwm_duty255", n, 32'd255);

      // Prescale write restarts tick spacing (ticks at E1, E9, then E20 after the E12 rewrite)
      do_reset();
      wr(5'd3, 32'd7);
      wr(5'd0, 32'h1);
      wr(5'd4, 32'h00D);
      repeat (8) @(negedge clk);
      check("presc_pre", 32'(leds[0]), 32'h1);
      wr(5'd3, 32'd7);
      repeat (8) @(negedge clk);
      check("presc_restart_hi", 32'(leds[0]), 32'h1);
      @(negedge clk);
      check("presc_restart_lo", 32'(leds[0]), 32'h0);

      // Reset in the middle of a PWM high phase (ch1 duty 1 marks pwm_cnt wrap)
      do_reset();
      wr(5'd0, 32'h3);
      wr(5'd5, 32'h005);
      wr(5'd4, 32'h321);
      found = 1'b0;
      for (int k = 0; k < 600 && !found; k++) begin
         @(negedge clk);
         if (leds[1]) found = 1'b1;
      end
      check("pwm_sync", 32'(found), 32'h1);
      repeat (99) @(negedge clk);
      check("mid_pwm_hi", 32'(leds[0]), 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_leds", 32'(leds), 32'h0);
      rst_n = 1'b1;
      rd_check("mid_rst_ch0", 5'd4, 32'h0);
      rd_check("mid_rst_ch1", 5'd5, 32'h0);
      rd_check("mid_rst_data", 5'd0, 32'h0);
      wr(5'd0, 32'h3);
      @(negedge clk);
      check("post_rst_direct", 32'(leds), 32'h3);

      // Blink with prescale 1: blink_cnt reaches 128 at edge 65535
      do_reset();
      bus.avs_address   = 5'd3;
      bus.avs_writedata = 32'd1;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
      wr(5'd0, 32'h4);
      wr(5'd6, 32'h2);
      repeat (65535 - 3) @(negedge clk);
      check("blink_pre", 32'(leds[2]), 32'h0);
      @(negedge clk);
      check("blink_rise", 32'(leds[2]), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
